// File: rtl/dac_batch_buffer.sv
// Elastic FWFT batch FIFO feeding the RF DAC AXI-Stream port.
// Primes before streaming, throttles the generator, counts under/overflows.
module dac_batch_buffer #(
    parameter int BATCH_WIDTH = 256,
    parameter int DEPTH       = 8,
    parameter int RDY_MARGIN  = 2,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       clr_counts,
    input  logic [BATCH_WIDTH-1:0]     batch_in,
    input  logic                       batch_in_valid,
    output logic                       dac_rdy,
    output logic [BATCH_WIDTH-1:0]     m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [1:0]                 state,
    output logic [15:0]                underflow_cnt,
    output logic [15:0]                overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    localparam logic [OW-1:0] FULL_LVL  = OW'(DEPTH);
    localparam logic [OW-1:0] RDY_LVL   = OW'(DEPTH - RDY_MARGIN);
    localparam logic [OW-1:0] PRIME_LVL = OW'(PRIME_LEVEL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [BATCH_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [1:0]    state_q, state_d;
    logic          dac_rdy_q, dac_rdy_d;
    logic [15:0]   uf_cnt_q, uf_cnt_d;
    logic [15:0]   of_cnt_q, of_cnt_d;

    logic full, empty, push, pop, ovf_ev, uf_ev;

    assign full  = (occ_q == FULL_LVL);
    assign empty = (occ_q == '0);

    assign m_tvalid = (state_q == S_STREAM) && !empty;
    assign m_tdata  = mem[rd_ptr_q];
    assign pop      = m_tvalid && m_tready;

    // Flush swallows the write strobe entirely: no push, no overflow.
    assign push   = !flush && batch_in_valid && (!full || pop);
    assign ovf_ev = !flush && batch_in_valid && full && !pop;
    assign uf_ev  = !flush && (state_q == S_STREAM) && empty && m_tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        state_d  = state_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            state_d  = S_IDLE;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            occ_d = occ_q + OW'(push) - OW'(pop);
            case (state_q)
                S_IDLE:   if (push) state_d = S_PRIME;
                S_PRIME:  if (occ_d >= PRIME_LVL) state_d = S_STREAM;
                S_STREAM: if (uf_ev) state_d = S_PRIME;
                default:  state_d = S_IDLE;
            endcase
        end
        dac_rdy_d = (occ_d < RDY_LVL);
    end

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        of_cnt_d = of_cnt_q;
        if (clr_counts) begin
            uf_cnt_d = '0;
            of_cnt_d = '0;
        end else begin
            if (uf_ev && uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
            if (ovf_ev && of_cnt_q != 16'hFFFF) of_cnt_d = of_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= batch_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            state_q   <= S_IDLE;
            dac_rdy_q <= 1'b0;
            uf_cnt_q  <= '0;
            of_cnt_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            state_q   <= state_d;
            dac_rdy_q <= dac_rdy_d;
            uf_cnt_q  <= uf_cnt_d;
            of_cnt_q  <= of_cnt_d;
        end
    end

    assign dac_rdy       = dac_rdy_q;
    assign occupancy     = occ_q;
    assign state         = state_q;
    assign underflow_cnt = uf_cnt_q;
    assign overflow_cnt  = of_cnt_q;

endmodule
